// File: rtl/sram_note_loader.sv
`default_nettype none
// ============================================================================
// Module      : sram_note_loader
// Description : Writer side of the note-program SRAM interface. Assembles
//               little-endian 16-bit note words from an incoming byte stream
//               and writes them to external SRAM starting at address 0.
//               The load ends after the terminator word is written or when
//               the last SRAM address has been used.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_note_loader #(
    parameter int          ADDR_W    = 18,
    parameter int          WE_CYCLES = 2,
    parameter logic [15:0] END_WORD  = 16'hFFFF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              SRAM_WE,
    output logic              SRAM_CE,
    output logic              SRAM_OE,
    output logic              SRAM_LB,
    output logic              SRAM_UB,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic [15:0]       SRAM_DQ_OUT,
    output logic              SRAM_DQ_OE,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    // Write-pulse counter is sized to hold WE_CYCLES-1 (at least one bit).
    localparam int                 c_CNT_W    = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WE_CYCLES - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LO    = 3'd1;
    localparam logic [2:0] c_HI    = 3'd2;
    localparam logic [2:0] c_SETUP = 3'd3;
    localparam logic [2:0] c_WRITE = 3'd4;
    localparam logic [2:0] c_HOLD  = 3'd5;
    localparam logic [2:0] c_DONE  = 3'd6;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_lo;
    logic               r_in_ready;
    logic               r_we;
    logic               r_ce;
    logic               r_oe;
    logic               r_lb;
    logic               r_ub;
    logic [ADDR_W-1:0]  r_sram_a;
    logic [15:0]        r_dq_out;
    logic               r_dq_oe;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;
    logic [ADDR_W:0]    r_word_count;

    logic               w_xfer;

    assign w_xfer = in_valid & r_in_ready;

    // Loader FSM: every bus and status output is a register updated here.
    // SRAM_A doubles as the write pointer; it only moves after HOLD, when
    // WE is already high again.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_lo         <= '0;
            r_in_ready   <= 1'b0;
            r_we         <= 1'b1;
            r_ce         <= 1'b1;
            r_oe         <= 1'b1;
            r_lb         <= 1'b1;
            r_ub         <= 1'b1;
            r_sram_a     <= '0;
            r_dq_out     <= '0;
            r_dq_oe      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_oe <= 1'b1;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_sram_a     <= '0;
                        r_word_count <= '0;
                        r_done       <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_in_ready   <= 1'b1;
                        r_state      <= c_LO;
                    end
                end
                c_LO: begin
                    if (w_xfer) begin
                        r_lo    <= in_data;
                        r_state <= c_HI;
                    end
                end
                c_HI: begin
                    // Second byte completes the word: present address/data
                    // and select the chip while WE is still high.
                    if (w_xfer) begin
                        r_dq_out   <= {in_data, r_lo};
                        r_dq_oe    <= 1'b1;
                        r_ce       <= 1'b0;
                        r_lb       <= 1'b0;
                        r_ub       <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    r_we    <= 1'b0;
                    r_cnt   <= c_CNT_INIT;
                    r_state <= c_WRITE;
                end
                c_WRITE: begin
                    if (r_cnt == '0) begin
                        r_we         <= 1'b1;
                        r_word_count <= r_word_count + (ADDR_W+1)'(1);
                        r_state      <= c_HOLD;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                c_HOLD: begin
                    if (r_dq_out == END_WORD) begin
                        r_ce    <= 1'b1;
                        r_lb    <= 1'b1;
                        r_ub    <= 1'b1;
                        r_dq_oe <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end else if (r_sram_a == {ADDR_W{1'b1}}) begin
                        r_ce       <= 1'b1;
                        r_lb       <= 1'b1;
                        r_ub       <= 1'b1;
                        r_dq_oe    <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_overflow <= 1'b1;
                        r_state    <= c_DONE;
                    end else begin
                        r_ce       <= 1'b1;
                        r_lb       <= 1'b1;
                        r_ub       <= 1'b1;
                        r_dq_oe    <= 1'b0;
                        r_sram_a   <= r_sram_a + ADDR_W'(1);
                        r_in_ready <= 1'b1;
                        r_state    <= c_LO;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign SRAM_WE     = r_we;
    assign SRAM_CE     = r_ce;
    assign SRAM_OE     = r_oe;
    assign SRAM_LB     = r_lb;
    assign SRAM_UB     = r_ub;
    assign SRAM_A      = r_sram_a;
    assign SRAM_DQ_OUT = r_dq_out;
    assign SRAM_DQ_OE  = r_dq_oe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign word_count  = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_sram_note_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sram_note_loader
// Description : Directed self-checking bench for sram_note_loader. A full
//               size instance covers loading, throughput, start and reset
//               handling; a 3-bit-address instance covers SRAM-full stop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_note_loader;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        we, ce, oe, lb, ub;
    logic [17:0] a;
    logic [15:0] dq;
    logic        dq_oe, busy, done, overflow;
    logic [18:0] wc;

    logic        ov_start;
    logic        ov_in_ready;
    logic        ov_we, ov_ce, ov_oe, ov_lb, ov_ub;
    logic [2:0]  ov_a;
    logic [15:0] ov_dq;
    logic        ov_dq_oe, ov_busy, ov_done, ov_overflow;
    logic [3:0]  ov_wc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
        int          low;
        bit          ok;
    } wr_t;

    wr_t wq[$];
    wr_t wq2[$];

    sram_note_loader #(.ADDR_W(18), .WE_CYCLES(2), .END_WORD(16'hFFFF)) dut (
        .CLK(CLK), .RST(RST), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .SRAM_WE(we), .SRAM_CE(ce), .SRAM_OE(oe), .SRAM_LB(lb),
        .SRAM_UB(ub), .SRAM_A(a), .SRAM_DQ_OUT(dq), .SRAM_DQ_OE(dq_oe), .busy(busy),
        .done(done), .overflow(overflow), .word_count(wc)
    );

    sram_note_loader #(.ADDR_W(3), .WE_CYCLES(2), .END_WORD(16'hFFFF)) dut_ov (
        .CLK(CLK), .RST(RST), .start(ov_start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ov_in_ready), .SRAM_WE(ov_we), .SRAM_CE(ov_ce), .SRAM_OE(ov_oe),
        .SRAM_LB(ov_lb), .SRAM_UB(ov_ub), .SRAM_A(ov_a), .SRAM_DQ_OUT(ov_dq),
        .SRAM_DQ_OE(ov_dq_oe), .busy(ov_busy), .done(ov_done), .overflow(ov_overflow),
        .word_count(ov_wc)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    // Write monitor for the main instance: one record per WE low pulse,
    // flagging any change of A/DQ/CE/DQ_OE between SETUP and HOLD.
    logic        m_prev_we = 1'b1, m_prev_ce = 1'b1, m_prev_dqoe = 1'b0;
    logic [17:0] m_prev_a = '0, m_cap_a = '0;
    logic [15:0] m_prev_dq = '0, m_cap_dq = '0;
    bit          m_in_low = 1'b0, m_ok = 1'b0;
    int          m_low = 0;
    always @(negedge CLK) begin
        if (we === 1'b0) begin
            if (!m_in_low) begin
                m_in_low = 1'b1;
                m_low    = 1;
                m_cap_a  = a;
                m_cap_dq = dq;
                m_ok     = (m_prev_a === a) && (m_prev_dq === dq) && (m_prev_ce === 1'b0) &&
                           (m_prev_dqoe === 1'b1) && (m_prev_we === 1'b1) &&
                           (ce === 1'b0) && (dq_oe === 1'b1);
            end else begin
                m_low++;
                if (a !== m_cap_a || dq !== m_cap_dq || ce !== 1'b0 || dq_oe !== 1'b1)
                    m_ok = 1'b0;
            end
        end else if (m_in_low) begin
            m_in_low = 1'b0;
            if (a !== m_cap_a || dq !== m_cap_dq || ce !== 1'b0 || dq_oe !== 1'b1)
                m_ok = 1'b0;
            wq.push_back('{addr: m_cap_a, data: m_cap_dq, low: m_low, ok: m_ok});
        end
        m_prev_we   = we;
        m_prev_ce   = ce;
        m_prev_dqoe = dq_oe;
        m_prev_a    = a;
        m_prev_dq   = dq;
    end

    // Lighter monitor for the small instance: records address/data at each WE fall.
    logic ov_prev_we = 1'b1;
    always @(negedge CLK) begin
        if (ov_we === 1'b0 && ov_prev_we === 1'b1)
            wq2.push_back('{addr: {15'd0, ov_a}, data: ov_dq, low: 0, ok: 1'b1});
        ov_prev_we = ov_we;
    end

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) ov_start = 1'b1; else start = 1'b1;
        @(posedge CLK);
        #1;
        ov_start = 1'b0;
        start    = 1'b0;
    endtask

    // Called at posedge+1: present a byte, let it transfer on the first edge
    // where the selected loader is ready.
    task automatic send_byte(input logic [7:0] b, input bit sel);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!got && n < 40) begin
            @(negedge CLK);
            n++;
            if ((sel ? ov_in_ready : in_ready) === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL send_byte_timeout: byte=%h never accepted, required in_ready=1", b);
        end else begin
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int n;
        n = 0;
        while ((sel ? ov_done : done) !== 1'b1 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if ((sel ? ov_done : done) !== 1'b1) begin
            checks++; failures++;
            $display("FAIL wait_done_timeout: done=0 after %0d cycles, required 1", n);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLK);
        checks++;
        if ({we, ce, oe, lb, ub, dq_oe, in_ready, busy, done, overflow} !== 10'b11111_00000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required %b",
                     {we, ce, oe, lb, ub, dq_oe, in_ready, busy, done, overflow}, 10'b11111_00000);
        end
        checks++;
        if (a !== 18'd0) begin failures++; $display("FAIL reset_addr: got %h required 0", a); end
        checks++;
        if (dq !== 16'd0) begin failures++; $display("FAIL reset_dq: got %h required 0", dq); end
        checks++;
        if (wc !== 19'd0) begin failures++; $display("FAIL reset_count: got %0d required 0", wc); end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_basic_load();
        logic [7:0]  bts [6];
        logic [15:0] exp_d [3];
        bts   = '{8'h15, 8'h00, 8'h23, 8'h01, 8'hFF, 8'hFF};
        exp_d = '{16'h0015, 16'h0123, 16'hFFFF};
        wq.delete();
        pulse_start(1'b0);
        for (int i = 0; i < 6; i++) send_byte(bts[i], 1'b0);
        wait_done(1'b0);
        checks++;
        if (wq.size() != 3) begin failures++; $display("FAIL basic_nwrites: got %0d required 3", wq.size()); end
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            checks++;
            if (wq[i].addr !== 18'(i) || wq[i].data !== exp_d[i]) begin
                failures++;
                $display("FAIL basic_write%0d: got %h@%h required %h@%h", i, wq[i].data, wq[i].addr, exp_d[i], i);
            end
            checks++;
            if (wq[i].low != 2 || !wq[i].ok) begin
                failures++;
                $display("FAIL basic_timing%0d: got we_low=%0d stable=%0d required 2 and 1", i, wq[i].low, wq[i].ok);
            end
        end
        checks++;
        if ({done, busy, overflow} !== 3'b100 || wc !== 19'd3) begin
            failures++;
            $display("FAIL basic_status: got done/busy/ovf=%b count=%0d required 100 count=3", {done, busy, overflow}, wc);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bts [8];
        logic [15:0] exp_d [4];
        int idx, cyc, lowc;
        bit pending;
        bts   = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80, 8'hFF, 8'hFF};
        exp_d = '{16'h1234, 16'hABCD, 16'h8001, 16'hFFFF};
        wq.delete();
        pulse_start(1'b0);
        idx = 0; cyc = 0; lowc = 0; pending = 1'b0;
        in_data  = bts[0];
        in_valid = 1'b1;
        while (idx < 8 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (in_ready === 1'b1) begin
                if (pending) begin
                    checks++;
                    if (lowc != 4) begin
                        failures++;
                        $display("FAIL b2b_gap_after_byte%0d: got %0d not-ready cycles required 4", idx, lowc);
                    end
                    pending = 1'b0;
                end
                @(posedge CLK);
                #1;
                idx++;
                if (idx < 8) in_data = bts[idx];
                else in_valid = 1'b0;
                if (idx % 2 == 0 && idx < 8) begin
                    pending = 1'b1;
                    lowc    = 0;
                end
            end else if (pending) begin
                lowc++;
            end
        end
        in_valid = 1'b0;
        if (idx < 8) begin
            checks++; failures++;
            $display("FAIL b2b_timeout: got %0d bytes accepted required 8", idx);
        end
        wait_done(1'b0);
        checks++;
        if (wq.size() != 4 || wc !== 19'd4) begin
            failures++;
            $display("FAIL b2b_nwrites: got %0d writes count=%0d required 4 and 4", wq.size(), wc);
        end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            checks++;
            if (wq[i].addr !== 18'(i) || wq[i].data !== exp_d[i] || wq[i].low != 2 || !wq[i].ok) begin
                failures++;
                $display("FAIL b2b_write%0d: got %h@%h low=%0d ok=%0d required %h@%h low=2 ok=1",
                         i, wq[i].data, wq[i].addr, wq[i].low, wq[i].ok, exp_d[i], i);
            end
        end
    endtask

    task automatic test_start_mid_load();
        wq.delete();
        pulse_start(1'b0);
        send_byte(8'h11, 1'b0);
        pulse_start(1'b0);
        send_byte(8'h22, 1'b0);
        pulse_start(1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        wait_done(1'b0);
        checks++;
        if (wq.size() != 2 || wc !== 19'd2) begin
            failures++;
            $display("FAIL midstart_nwrites: got %0d writes count=%0d required 2 and 2", wq.size(), wc);
        end else begin
            checks++;
            if (wq[0].addr !== 18'd0 || wq[0].data !== 16'h2211 || wq[1].addr !== 18'd1) begin
                failures++;
                $display("FAIL midstart_writes: got %h@%h then @%h required 2211@0 then @1",
                         wq[0].data, wq[0].addr, wq[1].addr);
            end
        end
    endtask

    task automatic test_start_in_done();
        pulse_start(1'b0);
        checks++;
        if ({done, busy} !== 2'b01 || wc !== 19'd0) begin
            failures++;
            $display("FAIL done_restart_status: got done/busy=%b count=%0d required 01 count=0", {done, busy}, wc);
        end
        wq.delete();
        send_byte(8'h42, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        wait_done(1'b0);
        checks++;
        if (wq.size() < 1 || wq[0].addr !== 18'd0 || wq[0].data !== 16'h0042) begin
            failures++;
            $display("FAIL done_restart_write: got %0d writes, first %h@%h required 0042@0",
                     wq.size(), (wq.size() > 0) ? wq[0].data : 16'hxxxx, (wq.size() > 0) ? wq[0].addr : 18'hx);
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        pulse_start(1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h03, 1'b0);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (we !== 1'b0 && n < 20);
        checks++;
        if (we !== 1'b0 || wc !== 19'd1) begin
            failures++;
            $display("FAIL rstmid_pre: got we=%b count=%0d required we=0 count=1", we, wc);
        end
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({we, ce, lb, ub, dq_oe, busy} !== 6'b111100 || wc !== 19'd0) begin
            failures++;
            $display("FAIL rstmid_after: got we/ce/lb/ub/dqoe/busy=%b count=%0d required 111100 count=0",
                     {we, ce, lb, ub, dq_oe, busy}, wc);
        end
        @(posedge CLK);
        #1;
        wq.delete();
        pulse_start(1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        wait_done(1'b0);
        checks++;
        if (wq.size() != 2 || wq[0].addr !== 18'd0 || wq[0].data !== 16'h6677 || wc !== 19'd2) begin
            failures++;
            $display("FAIL rstmid_reload: got %0d writes count=%0d first %h@%h required 2 writes count=2 6677@0",
                     wq.size(), wc, (wq.size() > 0) ? wq[0].data : 16'hxxxx, (wq.size() > 0) ? wq[0].addr : 18'hx);
        end
    endtask

    task automatic test_idle_bus();
        bit bad_done, bad_idle;
        bad_done = 1'b0;
        bad_idle = 1'b0;
        wq.delete();
        in_data  = 8'h55;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (in_ready !== 1'b0 || dq_oe !== 1'b0 || ce !== 1'b1 || oe !== 1'b1) bad_done = 1'b1;
        end
        checks++;
        if (bad_done) begin
            failures++;
            $display("FAIL idle_bus_done: got in_ready/dq_oe/ce/oe=%b%b%b%b required 0011", in_ready, dq_oe, ce, oe);
        end
        @(posedge CLK);
        #1;
        do_reset();
        repeat (3) begin
            @(negedge CLK);
            if (in_ready !== 1'b0 || dq_oe !== 1'b0 || ce !== 1'b1 || oe !== 1'b1) bad_idle = 1'b1;
        end
        checks++;
        if (bad_idle) begin
            failures++;
            $display("FAIL idle_bus_idle: got in_ready/dq_oe/ce/oe=%b%b%b%b required 0011", in_ready, dq_oe, ce, oe);
        end
        in_valid = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (wq.size() != 0 || wc !== 19'd0) begin
            failures++;
            $display("FAIL idle_bus_nowrite: got %0d writes count=%0d required 0 and 0", wq.size(), wc);
        end
    endtask

    task automatic test_overflow();
        bit took;
        took = 1'b0;
        wq2.delete();
        pulse_start(1'b1);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i), 1'b1);
            send_byte(8'h10, 1'b1);
        end
        wait_done(1'b1);
        checks++;
        if (wq2.size() != 8) begin
            failures++;
            $display("FAIL ovf_nwrites: got %0d required 8", wq2.size());
        end
        for (int i = 0; i < 8 && i < wq2.size(); i++) begin
            checks++;
            if (wq2[i].addr !== 18'(i) || wq2[i].data !== (16'h1000 | 16'(i))) begin
                failures++;
                $display("FAIL ovf_write%0d: got %h@%h required %h@%h", i, wq2[i].data, wq2[i].addr, 16'h1000 | 16'(i), i);
            end
        end
        checks++;
        if ({ov_done, ov_busy, ov_overflow} !== 3'b101 || ov_wc !== 4'd8) begin
            failures++;
            $display("FAIL ovf_status: got done/busy/ovf=%b count=%0d required 101 count=8",
                     {ov_done, ov_busy, ov_overflow}, ov_wc);
        end
        in_data  = 8'h99;
        in_valid = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            if (ov_in_ready !== 1'b0) took = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (took || ov_wc !== 4'd8) begin
            failures++;
            $display("FAIL ovf_ninth_byte: got ready_seen=%0d count=%0d required 0 and 8", took, ov_wc);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST      = 1'b1;
        start    = 1'b0;
        ov_start = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        test_reset();
        test_basic_load();
        test_back_to_back();
        test_start_mid_load();
        test_start_in_done();
        test_reset_mid_write();
        test_idle_bus();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
